shift_seq_ctrl: RTL and testbench



---
 rtl/logic_proc_pkg.sv | 18 +
 rtl/shift_counter.sv | 40 ++++
 rtl/shift_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_proc_pkg.sv
// ---------------------------------------------------------------------------
// logic_proc_pkg
// Shared types and constants for the logic processor control path.
//   DEFAULT_WIDTH : default register width, which is also the default
//                   number of shift cycles per operation
//   ctrl_state_t  : state encoding of the shift sequencer FSM
// ---------------------------------------------------------------------------
package logic_proc_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/shift_counter.sv
// ---------------------------------------------------------------------------
// shift_counter
// Counts the shifts completed in the current operation.
//   Clk      : system clock
//   Reset    : asynchronous, active-high clear
//   clear    : synchronous clear to 0 (has priority over enable)
//   enable   : increment by one at the next edge
//   count    : shifts completed, $clog2(N+1) bits so N itself fits
//   terminal : high when count == N-1 (the last shift is in progress)
// ---------------------------------------------------------------------------
module shift_counter
    import logic_proc_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     clear,
    input  logic                     enable,
    output logic [$clog2(N+1)-1:0]   count,
    output logic                     terminal
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            // The FSM stops enabling once count reaches N, so this never wraps.
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
// Sequences the 8-bit shift-register datapath: gates load requests into
// register load strobes and, on Execute, runs exactly N shift cycles, then
// waits in HOLD until Execute is released (one press = one operation).
//
//   Clk       : system clock
//   Reset     : asynchronous, active-high
//   Execute   : level request to run one operation
//   LoadA     : level request to parallel-load register A
//   LoadB     : level request to parallel-load register B
//   Ld_A      : load strobe to register A (only in IDLE)
//   Ld_B      : load strobe to register B (only in IDLE)
//   Shift_En  : shift enable to both registers (SHIFT state)
//   Busy      : SHIFT or HOLD
//   Done      : HOLD
//   Shift_Cnt : shifts completed in the current operation
//   state_dbg : current FSM state, for observation
//
// Handshake: there is no valid/ready pair here. Requests are levels sampled
// on every rising edge; a load request present in IDLE wins over Execute
// on the same edge, and Execute is simply re-sampled on the next edge.
// ---------------------------------------------------------------------------
module shift_seq_ctrl
    import logic_proc_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Execute,
    input  logic                     LoadA,
    input  logic                     LoadB,
    output logic                     Ld_A,
    output logic                     Ld_B,
    output logic                     Shift_En,
    output logic                     Busy,
    output logic                     Done,
    output logic [$clog2(N+1)-1:0]   Shift_Cnt,
    output logic [1:0]               state_dbg
);

    ctrl_state_t state;
    ctrl_state_t state_next;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_terminal;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (Execute && !LoadA && !LoadB) begin
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                state_next = cnt_terminal ? HOLD : SHIFT;
            end
            HOLD: begin
                state_next = Execute ? HOLD : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode; load strobes are the only Mealy outputs
    always_comb begin
        Ld_A       = 1'b0;
        Ld_B       = 1'b0;
        Shift_En   = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state)
            IDLE: begin
                Ld_A      = LoadA;
                Ld_B      = LoadB;
                cnt_clear = 1'b1;
            end
            SHIFT: begin
                Shift_En   = 1'b1;
                Busy       = 1'b1;
                cnt_enable = 1'b1;
            end
            HOLD: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                // Clear on the way out so IDLE always shows a zero count.
                cnt_clear = !Execute;
            end
            default: begin
                cnt_clear = 1'b1;
            end
        endcase
    end

    shift_counter #(
        .N (N)
    ) u_counter (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (Shift_Cnt),
        .terminal (cnt_terminal)
    );

    assign state_dbg = state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Directed bench for shift_seq_ctrl: one N=8 instance and one N=1 instance
// sharing clock, reset and request inputs. Inputs change 2 time units after
// each rising edge; outputs are checked 1 unit later, well before the next
// edge.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;
    import logic_proc_pkg::*;

    logic Clk;
    logic Reset;
    logic Execute;
    logic LoadA;
    logic LoadB;

    logic       ld_a8, ld_b8, sh8, busy8, done8;
    logic [3:0] cnt8;
    logic [1:0] st8;

    logic       ld_a1, ld_b1, sh1, busy1, done1;
    logic [0:0] cnt1;
    logic [1:0] st1;

    int tests;
    int fails;

    shift_seq_ctrl #(.N(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Execute   (Execute),
        .LoadA     (LoadA),
        .LoadB     (LoadB),
        .Ld_A      (ld_a8),
        .Ld_B      (ld_b8),
        .Shift_En  (sh8),
        .Busy      (busy8),
        .Done      (done8),
        .Shift_Cnt (cnt8),
        .state_dbg (st8)
    );

    shift_seq_ctrl #(.N(1)) dut1 (
        .Clk       (Clk),
        .Reset     (Reset),
        .Execute   (Execute),
        .LoadA     (LoadA),
        .LoadB     (LoadB),
        .Ld_A      (ld_a1),
        .Ld_B      (ld_b1),
        .Shift_En  (sh1),
        .Busy      (busy1),
        .Done      (done1),
        .Shift_Cnt (cnt1),
        .state_dbg (st1)
    );

    // Clock / reset infrastructure
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Driver / checker tasks
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all8(input string tag, input logic [1:0] st, input logic sh,
                            input logic busy, input logic done, input int cnt);
        chk({tag, ".state"},    32'(st8),   32'(st));
        chk({tag, ".shift_en"}, 32'(sh8),   32'(sh));
        chk({tag, ".busy"},     32'(busy8), 32'(busy));
        chk({tag, ".done"},     32'(done8), 32'(done));
        chk({tag, ".cnt"},      32'(cnt8),  32'(cnt));
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        Reset   = 1'b1;
        Execute = 1'b0;
        LoadA   = 1'b0;
        LoadB   = 1'b0;

        // Reset state
        repeat (2) @(posedge Clk);
        #2;
        chk_all8("rst", IDLE, 1'b0, 1'b0, 1'b0, 0);
        chk("rst.ld_a", 32'(ld_a8), 32'd0);
        chk("rst.ld_b", 32'(ld_b8), 32'd0);
        Reset = 1'b0;

        // Idle with all inputs low for 5 cycles
        repeat (5) tick();
        chk_all8("idle5", IDLE, 1'b0, 1'b0, 1'b0, 0);

        // Single load A
        LoadA = 1'b1;
        #1;
        chk("loada.ld_a", 32'(ld_a8), 32'd1);
        chk("loada.ld_b", 32'(ld_b8), 32'd0);
        tick();
        LoadA = 1'b0;
        #1;
        chk("loada_off.ld_a", 32'(ld_a8), 32'd0);
        chk("loada_off.state", 32'(st8), 32'(IDLE));

        // Both loads together
        tick();
        LoadA = 1'b1;
        LoadB = 1'b1;
        #1;
        chk("loadab.ld_a", 32'(ld_a8), 32'd1);
        chk("loadab.ld_b", 32'(ld_b8), 32'd1);
        tick();
        LoadA = 1'b0;
        LoadB = 1'b0;

        // Basic operation: Execute held for 20 cycles
        Execute = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 3) LoadA = 1'b1;
            #1;
            chk_all8($sformatf("op.s%0d", i), SHIFT, 1'b1, 1'b1, 1'b0, i);
            if (i == 3) begin
                chk("op.ld_a_in_shift", 32'(ld_a8), 32'd0);
                LoadA = 1'b0;
            end
        end
        for (int i = 0; i < 11; i++) begin
            tick();
            #1;
            chk_all8($sformatf("op.h%0d", i), HOLD, 1'b0, 1'b1, 1'b1, 8);
        end
        tick();
        Execute = 1'b0;
        #1;
        chk_all8("op.h_last", HOLD, 1'b0, 1'b1, 1'b1, 8);
        tick();
        #1;
        chk_all8("op.release", IDLE, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("op.no_rerun%0d", i), 32'(sh8), 32'd0);
        end

        // Short press: Execute high for a single sampled edge
        Execute = 1'b1;
        tick();
        Execute = 1'b0;
        #1;
        chk_all8("short.s0", SHIFT, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 1; i < 8; i++) begin
            tick();
            #1;
            chk_all8($sformatf("short.s%0d", i), SHIFT, 1'b1, 1'b1, 1'b0, i);
        end
        tick();
        #1;
        chk_all8("short.hold", HOLD, 1'b0, 1'b1, 1'b1, 8);
        tick();
        #1;
        chk_all8("short.idle", IDLE, 1'b0, 1'b0, 1'b0, 0);

        // Priority: load and Execute on the same edge
        Execute = 1'b1;
        LoadB   = 1'b1;
        #1;
        chk("prio.ld_b", 32'(ld_b8), 32'd1);
        tick();
        LoadB = 1'b0;
        #1;
        chk_all8("prio.held", IDLE, 1'b0, 1'b0, 1'b0, 0);
        chk("prio.ld_b_off", 32'(ld_b8), 32'd0);
        tick();
        #1;
        chk_all8("prio.start", SHIFT, 1'b1, 1'b1, 1'b0, 0);

        // Abort after 3 shifts via asynchronous reset between edges
        repeat (3) tick();
        #1;
        chk_all8("abort.pre", SHIFT, 1'b1, 1'b1, 1'b0, 3);
        Reset = 1'b1;
        #1;
        chk_all8("abort.async", IDLE, 1'b0, 1'b0, 1'b0, 0);
        Execute = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        #1;
        chk_all8("abort.after", IDLE, 1'b0, 1'b0, 1'b0, 0);

        // N=1 instance: one shift cycle, then HOLD with count 1
        chk("n1.idle.state", 32'(st1), 32'(IDLE));
        Execute = 1'b1;
        tick();
        Execute = 1'b0;
        #1;
        chk("n1.shift.state", 32'(st1),  32'(SHIFT));
        chk("n1.shift.en",    32'(sh1),  32'd1);
        chk("n1.shift.cnt",   32'(cnt1), 32'd0);
        tick();
        #1;
        chk("n1.hold.state", 32'(st1),   32'(HOLD));
        chk("n1.hold.en",    32'(sh1),   32'd0);
        chk("n1.hold.done",  32'(done1), 32'd1);
        chk("n1.hold.busy",  32'(busy1), 32'd1);
        chk("n1.hold.cnt",   32'(cnt1),  32'd1);
        tick();
        #1;
        chk("n1.idle2.state", 32'(st1),   32'(IDLE));
        chk("n1.idle2.done",  32'(done1), 32'd0);
        chk("n1.idle2.cnt",   32'(cnt1),  32'd0);
        chk("n1.idle2.ld",    32'({ld_a1, ld_b1}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
